// File: rtl/mips_pkg.sv
// Shared MIPS front-end constants: address geometry, opcode values, fetch FSM states.
package mips_pkg;

    localparam int PC_W       = 10;
    localparam int IMEM_DEPTH = 1000;

    localparam logic [5:0] OPC_RTYPE = 6'b000001;
    localparam logic [5:0] OPC_LW    = 6'b000010;
    localparam logic [5:0] OPC_SW    = 6'b000011;
    localparam logic [5:0] OPC_HALT  = 6'b111111;

    typedef enum logic {RUN, HALT} fetch_state_e;

    function automatic logic [5:0] opcode_of(input logic [31:0] word);
        return word[31:26];
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry {pc, instr} FIFO between instruction memory and decode; slot 0 is always the head.
module fetch_skid_buffer #(
    parameter int PC_W = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [PC_W-1:0] push_pc,
    input  logic [31:0]     push_instr,
    input  logic            pop,
    input  logic            flush,
    output logic [1:0]      occ,
    output logic [PC_W-1:0] head_pc,
    output logic [31:0]     head_instr
);

    logic [1:0][PC_W-1:0] pc_q, pc_d;
    logic [1:0][31:0]     instr_q, instr_d;
    logic [1:0]           occ_q, occ_d;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        occ_d   = occ_q;
        if (pop) begin
            pc_d[0]    = pc_q[1];
            instr_d[0] = instr_q[1];
        end
        if (flush) begin
            occ_d = 2'd0;
        end else begin
            // The new word goes to whichever slot is first free after this cycle's pop.
            if (push) begin
                if (occ_q == 2'd0 || (occ_q == 2'd1 && pop)) begin
                    pc_d[0]    = push_pc;
                    instr_d[0] = push_instr;
                end else begin
                    pc_d[1]    = push_pc;
                    instr_d[1] = push_instr;
                end
            end
            occ_d = occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            instr_q <= '0;
            occ_q   <= 2'd0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            occ_q   <= occ_d;
        end
    end

    assign occ        = occ_q;
    assign head_pc    = pc_q[0];
    assign head_instr = instr_q[0];

endmodule

// File: rtl/fetch_unit.sv
// PC/fetch stage: issues word addresses to a 1-cycle instruction memory and feeds decode.
// Define FETCH_HALT_EN to stop fetching after a word with the HALT opcode arrives.
module fetch_unit #(
    parameter int              PC_W       = mips_pkg::PC_W,
    parameter int              IMEM_DEPTH = mips_pkg::IMEM_DEPTH,
    parameter logic [PC_W-1:0] RESET_PC   = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] imem_pc,
    input  logic [31:0]     imem_data,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_instr,
    output logic [PC_W-1:0] id_pc,
    output logic            halted
);
    import mips_pkg::*;

    localparam logic [PC_W-1:0] LAST_PC = PC_W'(IMEM_DEPTH - 1);
    localparam logic [PC_W:0]   DEPTH_X = (PC_W + 1)'(IMEM_DEPTH);

    logic [PC_W-1:0] pc_q, pc_d, inflight_pc_q, inflight_pc_d;
    logic            inflight_q, inflight_d;
    fetch_state_e    state_q, state_d;

    logic [1:0] occ;
    logic [2:0] credit;
    logic       pop, push, issue, halt_hit;

    assign pop  = id_valid & id_ready;
    // A redirect discards the word returning this cycle.
    assign push = inflight_q & ~redirect_valid;
    // occ + inflight never exceeds 2 and pop implies occ>0, so this cannot underflow.
    assign credit = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};

`ifdef FETCH_HALT_EN
    assign halt_hit = push && (state_q == RUN) && (opcode_of(imem_data) == OPC_HALT);
    assign halted   = (state_q == HALT);
`else
    assign halt_hit = 1'b0;
    assign halted   = 1'b0;
`endif

    // Blocking issue on the halt word's arrival keeps imem_pc parked just past it.
    assign issue = (state_q == RUN) & ~redirect_valid & ~halt_hit & (credit < 3'd2);

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = issue ? pc_q : inflight_pc_q;
        state_d       = state_q;
        if (redirect_valid) begin
            pc_d    = ({1'b0, redirect_pc} >= DEPTH_X) ? '0 : redirect_pc;
            state_d = RUN;
        end else begin
            if (issue) pc_d = (pc_q == LAST_PC) ? '0 : pc_q + 1'b1;
            if (halt_hit) state_d = HALT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            state_q       <= RUN;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            state_q       <= state_d;
        end
    end

    fetch_skid_buffer #(.PC_W(PC_W)) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_pc    (inflight_pc_q),
        .push_instr (imem_data),
        .pop        (pop),
        .flush      (redirect_valid),
        .occ        (occ),
        .head_pc    (id_pc),
        .head_instr (id_instr)
    );

    assign imem_pc  = pc_q;
    assign id_valid = (occ != 2'd0);

endmodule
